// File: rtl/relay_frame_detector.sv
`default_nettype none
// ============================================================================
// relay_frame_detector : divided-rate relay bitstream framer driving mod_type
// Rev 1.0
// ============================================================================
module relay_frame_detector #(
   parameter int                 DIV_W          = 4,
   parameter int                 SHIFT_W        = 24,
   parameter int                 START_W        = 8,
   parameter logic [START_W-1:0] START_PAT_RD   = 8'hc0,
   parameter logic [START_W-1:0] START_PAT_TG   = 8'hf0,
   parameter int                 END_W          = 16,
   parameter logic [END_W-1:0]   END_PAT_RD_A   = 16'h0000,
   parameter logic [END_W-1:0]   END_PAT_RD_B   = 16'hc000,
   parameter logic [END_W-1:0]   END_PAT_TG     = 16'h0000,
   parameter int                 MAX_FRAME_BITS = 1024,
   parameter int                 CNT_W          = 16
) (
   input  logic             ck_1356meg,
   input  logic             rst,
   input  logic             enable,
   input  logic             role,
   input  logic             serial_in,
   output logic [2:0]       mod_type,
   output logic             active,
   output logic [7:0]       data_byte,
   output logic             data_valid,
   output logic             timeout,
   output logic [CNT_W-1:0] frame_count
);

   localparam int                 TCNT_W    = $clog2(MAX_FRAME_BITS + 1);
   localparam logic [DIV_W-1:0]   TICK_AT   = DIV_W'(2 ** (DIV_W - 1));
   localparam logic [TCNT_W-1:0]  TCNT_MAX  = TCNT_W'(MAX_FRAME_BITS);
   localparam logic [SHIFT_W-1:0] START_RD  = SHIFT_W'(START_PAT_RD);
   localparam logic [SHIFT_W-1:0] START_TG  = SHIFT_W'(START_PAT_TG);
   localparam logic [SHIFT_W-1:0] END_RD_A  = SHIFT_W'(END_PAT_RD_A) << (SHIFT_W - END_W);
   localparam logic [SHIFT_W-1:0] END_RD_B  = SHIFT_W'(END_PAT_RD_B) << (SHIFT_W - END_W);
   localparam logic [SHIFT_W-1:0] END_TG    = SHIFT_W'(END_PAT_TG) << (SHIFT_W - END_W);

   typedef enum logic [0:0] {
      ST_LISTEN = 1'b0,
      ST_MOD    = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [SHIFT_W-1:0] sh_q, sh_d;
   logic [2:0]         bcnt_q, bcnt_d;
   logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
   logic [CNT_W-1:0]   frame_count_q, frame_count_d;
   logic [7:0]         data_byte_q, data_byte_d;
   logic               data_valid_q, data_valid_d;
   logic               timeout_q, timeout_d;
   logic               role_q, role_d;

   logic               tick;
   logic [SHIFT_W-1:0] sh_shift;
   logic [2:0]         bcnt_inc;
   logic [TCNT_W-1:0]  tcnt_inc;
   logic               start_hit;
   logic               end_hit;
   logic               mod_active;

   always_comb begin
      state_d       = state_q;
      div_d         = div_q + 1'b1;
      sh_d          = sh_q;
      bcnt_d        = bcnt_q;
      tcnt_d        = tcnt_q;
      frame_count_d = frame_count_q;
      data_byte_d   = data_byte_q;
      data_valid_d  = 1'b0;
      timeout_d     = 1'b0;
      role_d        = role;

      tick      = (div_q == TICK_AT);
      sh_shift  = {sh_q[SHIFT_W-2:0], serial_in};
      bcnt_inc  = bcnt_q + 3'd1;
      tcnt_inc  = tcnt_q + 1'b1;
      start_hit = role ? (sh_shift == START_TG) : (sh_shift == START_RD);
      end_hit   = (bcnt_inc == 3'd0) &&
                  (role ? (sh_shift == END_TG)
                        : ((sh_shift == END_RD_A) || (sh_shift == END_RD_B)));

      // A role flip is treated exactly like a one-cycle disable: silent abort.
      if (!enable || (role != role_q)) begin
         state_d = ST_LISTEN;
         sh_d    = '0;
         bcnt_d  = '0;
         tcnt_d  = '0;
      end else if (tick) begin
         sh_d   = sh_shift;
         bcnt_d = bcnt_inc;
         case (state_q)
            ST_LISTEN: begin
               if (start_hit) begin
                  state_d = ST_MOD;
                  bcnt_d  = '0;
                  tcnt_d  = '0;
               end
            end
            ST_MOD: begin
               tcnt_d = tcnt_inc;
               if (end_hit) begin
                  state_d       = ST_LISTEN;
                  frame_count_d = frame_count_q + 1'b1;
               end else begin
                  if (bcnt_inc == 3'd0) begin
                     data_byte_d  = sh_shift[7:0];
                     data_valid_d = 1'b1;
                  end
                  if (tcnt_inc == TCNT_MAX) begin
                     state_d   = ST_LISTEN;
                     timeout_d = 1'b1;
                  end
               end
            end
            default: state_d = ST_LISTEN;
         endcase
      end
   end

   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         state_q       <= ST_LISTEN;
         div_q         <= '0;
         sh_q          <= '0;
         bcnt_q        <= '0;
         tcnt_q        <= '0;
         frame_count_q <= '0;
         data_byte_q   <= '0;
         data_valid_q  <= 1'b0;
         timeout_q     <= 1'b0;
         role_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         sh_q          <= sh_d;
         bcnt_q        <= bcnt_d;
         tcnt_q        <= tcnt_d;
         frame_count_q <= frame_count_d;
         data_byte_q   <= data_byte_d;
         data_valid_q  <= data_valid_d;
         timeout_q     <= timeout_d;
         role_q        <= role_d;
      end
   end

   // Disable or a pending role flip shows the LISTEN code without waiting a cycle.
   assign mod_active  = (state_q == ST_MOD) && enable && (role == role_q);
   assign mod_type    = role ? (mod_active ? 3'b010 : 3'b001)
                             : (mod_active ? 3'b100 : 3'b011);
   assign active      = mod_active;
   assign data_byte   = data_byte_q;
   assign data_valid  = data_valid_q;
   assign timeout     = timeout_q;
   assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_relay_frame_detector.sv
`default_nettype none
// ============================================================================
// tb_relay_frame_detector : random + directed bench against a bit-window model
// Rev 1.0
// ============================================================================
module tb_relay_frame_detector;

   localparam int DIV_W = 2;
   localparam int P     = 4;
   localparam int MAXF  = 32;
   localparam logic [31:0] HMASK = 32'h00ff_ffff;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        role = 1'b0;
   logic        serial_in = 1'b0;
   logic [2:0]  mod_type;
   logic        active;
   logic [7:0]  data_byte;
   logic        data_valid;
   logic        timeout;
   logic [15:0] frame_count;

   relay_frame_detector #(
      .DIV_W(DIV_W),
      .MAX_FRAME_BITS(MAXF)
   ) dut (
      .ck_1356meg (clk),
      .rst        (rst),
      .enable     (enable),
      .role       (role),
      .serial_in  (serial_in),
      .mod_type   (mod_type),
      .active     (active),
      .data_byte  (data_byte),
      .data_valid (data_valid),
      .timeout    (timeout),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model: last 24 sampled bits, ticks since start, frame state.
   int          m_clk = 0;
   bit          m_mod = 0;
   int          m_k = 0;
   logic [31:0] m_hist = '0;
   logic [7:0]  m_byte = '0;
   bit          m_valid = 0;
   bit          m_to = 0;
   int          m_frames = 0;
   bit          m_role_prev = 0;
   bit          m_last_tick = 0;
   bit          m_armed = 0;
   bit          tk;
   bit          eff;
   logic [2:0]  exp_mt;

   function automatic logic [31:0] start_of(input bit r);
      return r ? 32'h0000_00f0 : 32'h0000_00c0;
   endfunction

   function automatic bit is_end(input logic [31:0] h, input bit r);
      if (r) return h == (32'h0000 << 8);
      return (h == (32'h0000 << 8)) || (h == (32'hc000 << 8));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always begin
      @(posedge clk);
      if (rst) begin
         m_clk = 0; m_mod = 0; m_k = 0; m_hist = '0; m_byte = '0;
         m_valid = 0; m_to = 0; m_frames = 0; m_role_prev = 0;
         m_last_tick = 0; m_armed = 1;
      end else begin
         tk = ((m_clk % P) == P / 2);
         m_clk++;
         m_last_tick = tk;
         m_valid = 0;
         m_to = 0;
         if (!enable || (role != m_role_prev)) begin
            m_mod = 0; m_hist = '0; m_k = 0;
         end else if (tk) begin
            m_hist = ((m_hist << 1) | {31'b0, serial_in}) & HMASK;
            if (!m_mod) begin
               if (m_hist == start_of(role)) begin
                  m_mod = 1;
                  m_k = 0;
               end
            end else begin
               m_k++;
               if ((m_k % 8 == 0) && is_end(m_hist, role)) begin
                  m_mod = 0;
                  m_frames++;
               end else begin
                  if (m_k % 8 == 0) begin
                     m_byte = m_hist[7:0];
                     m_valid = 1;
                  end
                  if (m_k == MAXF) begin
                     m_to = 1;
                     m_mod = 0;
                  end
               end
            end
         end
         m_role_prev = role;
      end
   end

   always begin
      @(negedge clk);
      if (m_armed) begin
         eff    = m_mod && enable && (role == m_role_prev);
         exp_mt = role ? (eff ? 3'b010 : 3'b001) : (eff ? 3'b100 : 3'b011);
         chk("mod_type", {29'b0, mod_type}, {29'b0, exp_mt});
         chk("active", {31'b0, active}, {31'b0, eff});
         chk("data_valid", {31'b0, data_valid}, {31'b0, m_valid});
         chk("timeout", {31'b0, timeout}, {31'b0, m_to});
         chk("data_byte", {24'b0, data_byte}, {24'b0, m_byte});
         chk("frame_count", {16'b0, frame_count}, m_frames & 32'hffff);
      end
   end

   task automatic send_bit(input bit b);
      int n;
      serial_in = b;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_last_tick && n < 2 * P);
      if (!m_last_tick) begin
         failures++;
         $display("FAIL tick_wait actual=none expected=tick within %0d cycles", 2 * P);
      end
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic send_zeros(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0);
   endtask

   task automatic set_ctl(input bit en, input bit r);
      @(posedge clk);
      #1;
      enable = en;
      role = r;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int sel;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_mod_type", {29'b0, mod_type}, 32'h3);
      chk("reset_frame_count", {16'b0, frame_count}, 32'h0);

      // Reader start, payload, end
      set_ctl(1'b1, 1'b0);
      send_zeros(16);
      send_byte(8'hc0);
      chk("rd_start_mod_type", {29'b0, mod_type}, 32'h4);
      chk("rd_start_active", {31'b0, active}, 32'h1);
      send_byte(8'ha5);
      chk("a5_valid", {31'b0, data_valid}, 32'h1);
      chk("a5_byte", {24'b0, data_byte}, 32'ha5);
      send_byte(8'hc0);
      send_byte(8'h00);
      send_byte(8'h00);
      chk("rd_end_mod_type", {29'b0, mod_type}, 32'h3);
      chk("rd_end_frames", {16'b0, frame_count}, 32'h1);
      chk("rd_end_no_strobe", {31'b0, data_valid}, 32'h0);

      // Misaligned ones; aligned end coincides with timeout budget
      send_byte(8'hc0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      send_zeros(12);
      chk("misaligned_still_mod", {31'b0, active}, 32'h1);
      send_zeros(16);
      chk("end_beats_timeout_frames", {16'b0, frame_count}, 32'h2);
      chk("end_beats_timeout_to", {31'b0, timeout}, 32'h0);

      // Tag role
      set_ctl(1'b1, 1'b1);
      send_byte(8'hc0);
      chk("tag_ignores_c0", {29'b0, mod_type}, 32'h1);
      send_zeros(16);
      send_byte(8'hf0);
      chk("tag_start", {29'b0, mod_type}, 32'h2);
      send_zeros(24);
      chk("tag_end", {29'b0, mod_type}, 32'h1);
      chk("tag_frames", {16'b0, frame_count}, 32'h3);

      // Timeout
      set_ctl(1'b1, 1'b0);
      send_zeros(16);
      send_byte(8'hc0);
      for (int i = 0; i < MAXF; i++) send_bit(1'b1);
      chk("timeout_strobe", {31'b0, timeout}, 32'h1);
      chk("timeout_state", {29'b0, mod_type}, 32'h3);
      chk("timeout_frames", {16'b0, frame_count}, 32'h3);

      // Reset mid-frame
      send_zeros(16);
      send_byte(8'hc0);
      send_zeros(3);
      pulse_reset();
      #1;
      chk("rst_mod_type", {29'b0, mod_type}, 32'h3);
      chk("rst_frames", {16'b0, frame_count}, 32'h0);

      // Role change mid-frame
      send_zeros(16);
      send_byte(8'hc0);
      send_zeros(5);
      @(posedge clk);
      #1 role = 1'b1;
      #1;
      chk("role_flip_mod_type", {29'b0, mod_type}, 32'h1);
      chk("role_flip_active", {31'b0, active}, 32'h0);
      send_zeros(8);
      chk("role_flip_no_frame", {16'b0, frame_count}, 32'h0);

      // Randomized traffic
      for (int it = 0; it < 260; it++) begin
         sel = $urandom_range(0, 11);
         case (sel)
            0, 1, 2: send_byte(8'($urandom));
            3, 4:    begin send_zeros(16); send_byte(role ? 8'hf0 : 8'hc0); end
            5:       send_zeros(24);
            6:       begin send_byte(8'hc0); send_zeros(16); end
            7:       begin
                        set_ctl(1'b0, role);
                        repeat ($urandom_range(1, 9)) @(posedge clk);
                        set_ctl(1'b1, role);
                     end
            8:       set_ctl(1'b1, ~role);
            9:       if ($urandom_range(0, 7) == 0) pulse_reset();
            default: for (int j = 0; j < int'($urandom_range(1, 5)); j++) send_bit(1'($urandom));
         endcase
      end

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL global_timeout actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
`default_nettype wire
